// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types, select modes and FSM encodings for the two-master system bus arbiter.
// Pure declarations: no latency, no flow control.
package sys_bus_arbiter_pkg;

   typedef logic [1:0]  SelectModeBus;
   typedef logic [31:0] MemAddressBus;
   typedef logic [31:0] MemByteBus;

   localparam SelectModeBus SEL_NONE  = 2'b00;
   localparam SelectModeBus SEL_READ  = 2'b01;
   localparam SelectModeBus SEL_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GNT_M0 = 2'b01,
      GNT_M1 = 2'b10
   } arb_state_t;

   typedef struct packed {
      MemAddressBus addr;
      MemByteBus    data;
      logic         rw;
   } bus_req_t;

   function automatic SelectModeBus sel_mode(input logic rw);
      return rw ? SEL_WRITE : SEL_READ;
   endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Master- and slave-side signal bundle of the shared bus; the arbiter uses the slave modport.
// Wires only: no latency; masters are stalled through the hold outputs.
interface sys_bus_arbiter_if #(
   parameter int SLAVE_NUM = 4
);
   import sys_bus_arbiter_pkg::*;

   logic                     m0_req_in,  m1_req_in;
   MemAddressBus             m0_addr_in, m1_addr_in;
   MemByteBus                m0_data_in, m1_data_in;
   logic                     m0_rw_in,   m1_rw_in;
   SelectModeBus             m0_select_as_out, m1_select_as_out;
   MemByteBus                m0_data_out, m1_data_out;
   logic                     m0_hold_out, m1_hold_out;
   MemAddressBus             s_addr_out;
   MemByteBus                s_data_out;
   logic                     s_rw_out;
   logic [2*SLAVE_NUM-1:0]   s_select_as_out;
   logic [32*SLAVE_NUM-1:0]  s_data_in;
   logic                     decode_err_out;

   modport slave (
      input  m0_req_in, m1_req_in, m0_addr_in, m1_addr_in,
             m0_data_in, m1_data_in, m0_rw_in, m1_rw_in, s_data_in,
      output m0_select_as_out, m1_select_as_out, m0_data_out, m1_data_out,
             m0_hold_out, m1_hold_out, s_addr_out, s_data_out, s_rw_out,
             s_select_as_out, decode_err_out
   );

   modport master (
      output m0_req_in, m1_req_in, m0_addr_in, m1_addr_in,
             m0_data_in, m1_data_in, m0_rw_in, m1_rw_in, s_data_in,
      input  m0_select_as_out, m1_select_as_out, m0_data_out, m1_data_out,
             m0_hold_out, m1_hold_out, s_addr_out, s_data_out, s_rw_out,
             s_select_as_out, decode_err_out
   );

endinterface

// File: rtl/sys_bus_arbiter_decoder.sv
// Address decoder: slave index from addr[DEC_HI:DEC_LO] to a one-hot per-slave select mode.
// Combinational; out-of-range indices select nothing and flag decode_err.
module bus_addr_decoder
   import sys_bus_arbiter_pkg::*;
#(
   parameter int SLAVE_NUM = 4,
   parameter int DEC_HI    = 31,
   parameter int DEC_LO    = 28,
   parameter int IDX_W     = DEC_HI - DEC_LO + 1
) (
   input  MemAddressBus           addr,
   input  logic                   rw,
   input  logic                   valid,
   output logic [2*SLAVE_NUM-1:0] select_as,
   output logic [IDX_W-1:0]       index,
   output logic                   decode_err
);

   logic in_range;
   logic unused_addr;

   assign index       = addr[DEC_HI:DEC_LO];
   assign unused_addr = ^addr;
   // one extra bit so SLAVE_NUM == 2**IDX_W still compares correctly
   assign in_range    = {1'b0, index} < (IDX_W + 1)'(SLAVE_NUM);
   assign decode_err  = valid & ~in_range;

   always_comb begin
      select_as = '0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (valid && in_range && index == IDX_W'(i)) begin
            select_as[2*i +: 2] = sel_mode(rw);
         end
      end
   end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded grant length and per-slave address decode.
// Grant one cycle after request from IDLE; losers see hold until granted, datapath is combinational.
module sys_bus_arbiter
   import sys_bus_arbiter_pkg::*;
#(
   parameter int SLAVE_NUM = 4,
   parameter int DEC_HI    = 31,
   parameter int DEC_LO    = 28,
   parameter int GRANT_MAX = 16
) (
   input logic              clk,
   input logic              rst,
   sys_bus_arbiter_if.slave bus
);

   localparam int IDX_W = DEC_HI - DEC_LO + 1;
   localparam int CNT_W = $clog2(GRANT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(GRANT_MAX);

   arb_state_t             state, state_nxt;
   logic                   last, last_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;

   logic                   gnt_m0, gnt_m1, granted;
   bus_req_t               m0_req, m1_req, gnt_req;
   logic [2*SLAVE_NUM-1:0] sel_vec;
   logic [IDX_W-1:0]       idx;
   logic                   dec_err;
   SelectModeBus           slave_mode;
   MemByteBus              rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Handover fires from GRANT_MAX-1 upward so a master that saturated the
   // counter while alone still yields as soon as the other one asks.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.m0_req_in && (!bus.m1_req_in || last)) state_nxt = GNT_M0;
            else if (bus.m1_req_in)                         state_nxt = GNT_M1;
         end
         GNT_M0: begin
            if (!bus.m0_req_in || (bus.m1_req_in && cnt >= CNT_LAST)) begin
               last_nxt  = 1'b0;
               state_nxt = bus.m1_req_in ? GNT_M1 : IDLE;
            end else if (cnt != CNT_SAT) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GNT_M1: begin
            if (!bus.m1_req_in || (bus.m0_req_in && cnt >= CNT_LAST)) begin
               last_nxt  = 1'b1;
               state_nxt = bus.m0_req_in ? GNT_M0 : IDLE;
            end else if (cnt != CNT_SAT) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   assign gnt_m0  = (state == GNT_M0);
   assign gnt_m1  = (state == GNT_M1);
   assign granted = gnt_m0 | gnt_m1;

   assign m0_req  = '{addr: bus.m0_addr_in, data: bus.m0_data_in, rw: bus.m0_rw_in};
   assign m1_req  = '{addr: bus.m1_addr_in, data: bus.m1_data_in, rw: bus.m1_rw_in};
   assign gnt_req = gnt_m0 ? m0_req : (gnt_m1 ? m1_req : '0);

   bus_addr_decoder #(
      .SLAVE_NUM (SLAVE_NUM),
      .DEC_HI    (DEC_HI),
      .DEC_LO    (DEC_LO),
      .IDX_W     (IDX_W)
   ) u_dec (
      .addr       (gnt_req.addr),
      .rw         (gnt_req.rw),
      .valid      (granted),
      .select_as  (sel_vec),
      .index      (idx),
      .decode_err (dec_err)
   );

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (granted && !dec_err && idx == IDX_W'(i)) rd_data = bus.s_data_in[32*i +: 32];
      end
   end

   assign slave_mode = (granted && !dec_err) ? sel_mode(gnt_req.rw) : SEL_NONE;

   assign bus.s_addr_out       = gnt_req.addr;
   assign bus.s_data_out       = gnt_req.data;
   assign bus.s_rw_out         = gnt_req.rw;
   assign bus.s_select_as_out  = sel_vec;
   assign bus.decode_err_out   = dec_err;

   assign bus.m0_select_as_out = gnt_m0 ? slave_mode : SEL_NONE;
   assign bus.m1_select_as_out = gnt_m1 ? slave_mode : SEL_NONE;
   assign bus.m0_data_out      = gnt_m0 ? rd_data : '0;
   assign bus.m1_data_out      = gnt_m1 ? rd_data : '0;
   assign bus.m0_hold_out      = bus.m0_req_in & ~gnt_m0;
   assign bus.m1_hold_out      = bus.m1_req_in & ~gnt_m1;

endmodule
